// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: collects N MSB-first bits framed by a
// start strobe and hands the word off through a registered valid/ready output.
module sipo_deser #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         start,
  input  logic         sin,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_n;
  logic [N-1:0]   sreg, sreg_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [N-1:0]   q_n;
  logic           q_valid_n, overrun_n;
  logic [N-1:0]   word;
  logic           done;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      q       <= q_n;
      q_valid <= q_valid_n;
      overrun <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    q_n       = q;
    q_valid_n = q_valid;
    overrun_n = overrun;
    done      = 1'b0;
    word      = {sreg[N-2:0], sin};

    if (q_valid && q_ready)
      q_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (en && start) begin
          sreg_n  = word;
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          sreg_n = word;
          if (start) begin
            cnt_n = CW'(1);
          end else if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A consume on the completion edge frees the slot for the new word.
    if (done) begin
      if (!q_valid || q_ready) begin
        q_n       = word;
        q_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed frames plus random traffic, compared every
// cycle against a bit-list model of the framing and handshake rules.
module tb_sipo_deser;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic         start = 1'b0;
  logic         sin = 1'b0;
  logic         q_ready = 1'b0;
  logic [N-1:0] q;
  logic         q_valid, busy, overrun;

  sipo_deser #(.N(N)) dut (
    .clk(clk), .clr(clr), .en(en), .start(start), .sin(sin),
    .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int           bits[$];
  bit           m_act = 1'b0;
  int unsigned  m_q = 0;
  bit           m_qv = 1'b0;
  bit           m_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit c, input bit e, input bit s, input bit d, input bit r);
    bit          done, qv_old;
    int unsigned w;
    if (!c) begin
      bits.delete(); m_act = 0; m_q = 0; m_qv = 0; m_ov = 0;
      return;
    end
    done = 0; w = 0; qv_old = m_qv;
    if (e) begin
      if (s) begin
        bits.delete(); bits.push_back(int'(d)); m_act = 1;
      end else if (m_act) begin
        bits.push_back(int'(d));
        if (bits.size() == N) begin
          foreach (bits[i]) w = w * 2 + bits[i];
          done = 1; m_act = 0; bits.delete();
        end
      end
    end
    if (qv_old && r) m_qv = 0;
    if (done) begin
      if (!qv_old || r) begin m_q = w; m_qv = 1; end
      else m_ov = 1;
    end
  endtask

  task automatic tick(input bit c, input bit e, input bit s, input bit d, input bit r);
    clr = c; en = e; start = s; sin = d; q_ready = r;
    @(posedge clk);
    model_edge(c, e, s, d, r);
    #1;
    check("q", 32'(q), m_q);
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("busy", 32'(busy), 32'(m_act));
    check("overrun", 32'(overrun), 32'(m_ov));
  endtask

  // Sends one MSB-first frame; q_ready is raised only with the final bit if asked.
  task automatic send_frame(input logic [N-1:0] w, input int gap, input bit rdy_last);
    for (int i = N - 1; i >= 0; i--) begin
      tick(1, 1, i == N - 1, w[i], (i == 0) ? rdy_last : 1'b0);
      if (i > 0) repeat (gap) tick(1, 0, 0, 0, 0);
    end
  endtask

  initial begin
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 1);
    check("rst_q", 32'(q), 0);
    check("rst_valid", 32'(q_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(overrun), 0);

    // 1: back-to-back frame then consume
    send_frame(4'b1011, 0, 0);
    check("t1_q", 32'(q), 32'hB);
    check("t1_valid", 32'(q_valid), 1);
    check("t1_busy", 32'(busy), 0);
    tick(1, 0, 0, 0, 1);
    check("t1_drain", 32'(q_valid), 0);
    check("t1_hold", 32'(q), 32'hB);

    // 2: gapped bits
    send_frame(4'b0110, 2, 0);
    check("t2_q", 32'(q), 32'h6);
    tick(1, 0, 0, 0, 1);

    // 3: overrun then reset
    send_frame(4'b1011, 0, 0);
    send_frame(4'b0101, 0, 0);
    check("t3_q", 32'(q), 32'hB);
    check("t3_ovr", 32'(overrun), 1);
    tick(0, 0, 0, 0, 0);
    check("t3_rst_q", 32'(q), 0);
    check("t3_rst_ovr", 32'(overrun), 0);

    // 4: consume and completion on the same edge
    send_frame(4'b1011, 0, 0);
    send_frame(4'b0101, 0, 1);
    check("t4_q", 32'(q), 32'h5);
    check("t4_valid", 32'(q_valid), 1);
    check("t4_ovr", 32'(overrun), 0);
    tick(1, 0, 0, 0, 1);

    // 5: restart mid-frame
    tick(1, 1, 1, 1, 0);
    tick(1, 1, 0, 1, 0);
    send_frame(4'b0011, 0, 0);
    check("t5_q", 32'(q), 32'h3);
    tick(1, 0, 0, 0, 1);

    // 6: reset mid-frame, stray bits, then a proper frame
    tick(1, 1, 1, 1, 0);
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_valid", 32'(q_valid), 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 1, 0);
    check("t6_stray", 32'(q_valid), 0);
    send_frame(4'b1001, 0, 0);
    check("t6_q", 32'(q), 32'h9);

    // random traffic
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(99) != 0, $urandom_range(2) != 0, $urandom_range(5) == 0,
           $urandom_range(1) == 1, $urandom_range(2) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
